sdram_wr_burst_fetch: RTL and testbench

- Sits directly downstream of the write-data synchronous FIFO and upstream of the SDRAM command/data sequencer.
- Pops write words from the FIFO and packs BURST_LEN of them into a local burst buffer.
- Requests a write burst at an auto-incrementing SDRAM address, then streams the beats to the sequencer under ready/valid backpressure.

---
 rtl/sdram_wr_burst_fetch.sv | 162 ++++++++++++++++
 tb/tb_sdram_wr_burst_fetch.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_wr_burst_fetch.sv
// Pops write words from the write-data FIFO, packs them into bursts and streams them to the SDRAM sequencer.
// Optional partial-burst timeout is compiled in with `define WR_BURST_TIMEOUT_EN.
module sdram_wr_burst_fetch #(
   parameter int WIDTH     = 16,
   parameter int BURST_LEN = 4,
   parameter int BL_SIZE   = 2,
   parameter int ADDR_W    = 22
`ifdef WR_BURST_TIMEOUT_EN
   ,
   parameter int TIMEOUT   = 64
`endif
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              fifo_empty,
   output logic              fifo_rd_en,
   input  logic [WIDTH-1:0]  fifo_rd_data,
   output logic              wr_req,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [BL_SIZE:0]  wr_len,
   input  logic              wr_gnt,
   output logic [WIDTH-1:0]  wr_data,
   output logic              wr_data_vld,
   input  logic              wr_data_rdy,
   output logic              busy,
   output logic [1:0]        dbg_state
);

   // Handshakes: wr_req is held with a stable wr_addr/wr_len until the one-cycle wr_gnt;
   // a beat transfers on a cycle with wr_data_vld && wr_data_rdy, and wr_data holds otherwise.
   typedef enum logic [1:0] {IDLE, FETCH, REQ, SEND} state_e;

   localparam logic [BL_SIZE:0] BL = (BL_SIZE+1)'(BURST_LEN);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [BL_SIZE:0]  issue_q, issue_d;
   logic [BL_SIZE:0]  cap_q, cap_d;
   logic [BL_SIZE:0]  beat_q, beat_d;
   logic [BL_SIZE:0]  len_q, len_d;
   logic              pop_q;
   logic [WIDTH-1:0]  mem_q [BURST_LEN];
   logic              can_pop;
   logic              last_cap;

`ifdef WR_BURST_TIMEOUT_EN
   localparam int IDLE_W = $clog2(TIMEOUT + 1);
   logic [IDLE_W-1:0] idle_q, idle_d;
   logic              partial_go;
   logic              idle_now;

   // Idle means a partial burst is buffered, nothing is in flight and nothing can be popped.
   always_comb begin
      idle_now   = (state_q == FETCH) && (cap_q != '0) && !pop_q && !can_pop;
      idle_d     = idle_now ? idle_q + 1'b1 : '0;
      partial_go = (cap_q != '0) && !pop_q &&
                   (!enable || (idle_now && (idle_q == IDLE_W'(TIMEOUT - 1))));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) idle_q <= '0;
      else        idle_q <= idle_d;
   end
`endif

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      issue_d     = issue_q;
      cap_d       = cap_q;
      beat_d      = beat_q;
      len_d       = len_q;
      fifo_rd_en  = 1'b0;
      wr_req      = 1'b0;
      wr_data_vld = 1'b0;
      can_pop     = !fifo_empty && (issue_q < BL);
      last_cap    = pop_q && (cap_q == BL - 1'b1);
      case (state_q)
         IDLE: begin
            if (enable) begin
               addr_d  = base_addr;
               state_d = FETCH;
            end
         end
         FETCH: begin
`ifdef WR_BURST_TIMEOUT_EN
            fifo_rd_en = can_pop && enable;
`else
            // A started burst must complete, so pops continue once any has been issued.
            fifo_rd_en = can_pop && (enable || (issue_q != '0));
`endif
            if (fifo_rd_en) issue_d = issue_q + 1'b1;
            if (pop_q)      cap_d   = cap_q + 1'b1;
            if (last_cap) begin
               state_d = REQ;
               len_d   = BL;
            end else if (!enable && (issue_q == '0)) begin
               state_d = IDLE;
            end
`ifdef WR_BURST_TIMEOUT_EN
            else if (partial_go) begin
               state_d = REQ;
               len_d   = cap_q;
            end
`endif
         end
         REQ: begin
            wr_req = 1'b1;
            if (wr_gnt) state_d = SEND;
         end
         SEND: begin
            wr_data_vld = 1'b1;
            if (wr_data_rdy) begin
               if (beat_q == len_q - 1'b1) begin
                  addr_d  = addr_q + ADDR_W'(len_q);
                  issue_d = '0;
                  cap_d   = '0;
                  beat_d  = '0;
                  state_d = enable ? FETCH : IDLE;
               end else begin
                  beat_d = beat_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         addr_q  <= '0;
         issue_q <= '0;
         cap_q   <= '0;
         beat_q  <= '0;
         len_q   <= BL;
         pop_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         issue_q <= issue_d;
         cap_q   <= cap_d;
         beat_q  <= beat_d;
         len_q   <= len_d;
         pop_q   <= fifo_rd_en;
      end
   end

   // FIFO data lands one cycle after its pop; the buffer needs no reset.
   always_ff @(posedge clk) begin
      if (pop_q) mem_q[cap_q[BL_SIZE-1:0]] <= fifo_rd_data;
   end

   assign wr_addr   = addr_q;
   assign wr_len    = len_q;
   assign wr_data   = (state_q == SEND) ? mem_q[beat_q[BL_SIZE-1:0]] : '0;
   assign busy      = (state_q != IDLE);
   assign dbg_state = state_q;

endmodule

// File: tb/tb_sdram_wr_burst_fetch.sv
// Bench for sdram_wr_burst_fetch: FIFO model, sequencer model, burst/data scoreboard.
// Build with +define+WR_BURST_TIMEOUT_EN to exercise the partial-burst path.
module tb_sdram_wr_burst_fetch;
   localparam int WIDTH = 16, BURST_LEN = 4, BL_SIZE = 2, ADDR_W = 22;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              enable = 1'b0;
   logic [ADDR_W-1:0] base_addr = '0;
   logic              fifo_empty = 1'b1;
   logic              fifo_rd_en;
   logic [WIDTH-1:0]  fifo_rd_data = '0;
   logic              wr_req;
   logic [ADDR_W-1:0] wr_addr;
   logic [BL_SIZE:0]  wr_len;
   logic              wr_gnt = 1'b0;
   logic [WIDTH-1:0]  wr_data;
   logic              wr_data_vld;
   logic              wr_data_rdy = 1'b1;
   logic              busy;
   logic [1:0]        dbg_state;

   sdram_wr_burst_fetch #(.WIDTH(WIDTH), .BURST_LEN(BURST_LEN), .BL_SIZE(BL_SIZE), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .base_addr(base_addr),
      .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_len(wr_len), .wr_gnt(wr_gnt),
      .wr_data(wr_data), .wr_data_vld(wr_data_vld), .wr_data_rdy(wr_data_rdy),
      .busy(busy), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [ADDR_W-1:0] base;
      int                gap;
      int                gnt_dly;
      bit                bp;
      logic [ADDR_W-1:0] exp_a0;
      logic [ADDR_W-1:0] exp_a1;
   } vec_t;

   logic [WIDTH-1:0]  fq[$];
   logic [WIDTH-1:0]  exp_q[$];
   logic [ADDR_W-1:0] exp_addr_q[$];
   int                exp_len_q[$];

   int checks = 0, passed = 0;
   int cyc, pops, beats, words_reqd, req_seen, req_cyc, req_cnt;
   int empty_viol, send_pop_viol, hold_viol, req_unstable;
   int gap, gap_cnt, to_feed, gnt_dly, bp_phase;
   bit bp, prev_req, held, gnt_next;
   logic [WIDTH-1:0]  held_data, feed_word;
   logic [ADDR_W-1:0] req_addr;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h, required %0h", name, act, exp);
   endtask

   task automatic push_word();
      fq.push_back(feed_word);
      exp_q.push_back(feed_word);
      feed_word = feed_word + 1'b1;
      to_feed--;
   endtask

   task automatic preload(input int n, input logic [WIDTH-1:0] first);
      feed_word = first;
      to_feed   = n;
      while (to_feed > 0) push_word();
      fifo_empty = (fq.size() == 0);
   endtask

   task automatic expect_burst(input logic [ADDR_W-1:0] a, input int len);
      exp_addr_q.push_back(a);
      exp_len_q.push_back(len);
   endtask

   task automatic clear_env();
      fq.delete(); exp_q.delete(); exp_addr_q.delete(); exp_len_q.delete();
      pops = 0; beats = 0; words_reqd = 0; req_seen = 0; req_cyc = 0; req_cnt = 0; cyc = 0;
      empty_viol = 0; send_pop_viol = 0; hold_viol = 0; req_unstable = 0;
      gap = 0; gap_cnt = 0; to_feed = 0; gnt_dly = 1; bp = 0; bp_phase = 0;
      prev_req = 0; held = 0; gnt_next = 0;
      wr_gnt = 1'b0; wr_data_rdy = 1'b1; fifo_empty = 1'b1; fifo_rd_data = '0;
   endtask

   task automatic check_reset_vals();
      check("rst_fifo_rd_en", fifo_rd_en, 0);
      check("rst_wr_req", wr_req, 0);
      check("rst_wr_data_vld", wr_data_vld, 0);
      check("rst_busy", busy, 0);
      check("rst_wr_addr", wr_addr, 0);
      check("rst_wr_len", wr_len, 4);
      check("rst_wr_data", wr_data, 0);
   endtask

   task automatic do_reset(input bit check_vals);
      @(posedge clk);
      #1;
      rst_n  = 1'b0;
      enable = 1'b0;
      clear_env();
      #1;
      if (check_vals) check_reset_vals();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // One cycle: observe at the falling edge, then update the FIFO/sequencer models after the rising edge.
   task automatic tick();
      logic do_pop;
      int   cur_len;
      @(negedge clk);
      cyc++;
      do_pop = fifo_rd_en;
      if (do_pop) begin
         pops++;
         if (fifo_empty) empty_viol++;
         if (wr_data_vld) send_pop_viol++;
      end
      if (wr_req && !prev_req) begin
         req_seen++;
         req_cyc  = cyc;
         req_cnt  = 0;
         req_addr = wr_addr;
         if (exp_addr_q.size() == 0 || exp_len_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_req: got request at %0h, required none", wr_addr);
         end else begin
            check("req_addr", wr_addr, exp_addr_q.pop_front());
            cur_len = exp_len_q.pop_front();
            check("req_len", wr_len, cur_len);
            words_reqd += cur_len;
            check("pops_before_req", pops, words_reqd);
         end
      end
      if (wr_req) begin
         req_cnt++;
         if (wr_addr != req_addr) req_unstable++;
         if (req_cnt == gnt_dly) gnt_next = 1;
      end else if (prev_req) begin
         check("req_cycles", req_cnt, gnt_dly + 1);
      end
      prev_req = wr_req;
      if (wr_data_vld) begin
         if (held && wr_data != held_data) hold_viol++;
         if (wr_data_rdy) begin
            beats++;
            held = 0;
            if (exp_q.size() == 0) begin
               checks++;
               $display("FAIL unexpected_beat: got %0h, required no beat", wr_data);
            end else begin
               check("beat_data", wr_data, exp_q.pop_front());
            end
         end else begin
            held      = 1;
            held_data = wr_data;
         end
      end else begin
         if (held) hold_viol++;
         held = 0;
      end
      @(posedge clk);
      #1;
      if (do_pop && fq.size() > 0) fifo_rd_data = fq.pop_front();
      if (to_feed > 0) begin
         if (gap_cnt == 0) begin
            push_word();
            gap_cnt = gap - 1;
         end else begin
            gap_cnt--;
         end
      end
      fifo_empty = (fq.size() == 0);
      wr_gnt     = gnt_next;
      gnt_next   = 0;
      if (bp) begin
         bp_phase    = (bp_phase + 1) % 3;
         wr_data_rdy = (bp_phase == 0);
      end else begin
         wr_data_rdy = 1'b1;
      end
   endtask

   task automatic run_until_beats(input int target, input int budget);
      for (int c = 0; c < budget && beats < target; c++) tick();
      check("beats_done", beats, target);
   endtask

   task automatic check_clean();
      check("no_pop_when_empty", empty_viol, 0);
      check("no_pop_in_send", send_pop_viol, 0);
      check("beat_hold", hold_viol, 0);
      check("req_stable", req_unstable, 0);
      check("scoreboard_drained", exp_q.size(), 0);
   endtask

   vec_t vecs[4];

   initial begin
      vecs[0] = '{base: 22'h000100, gap: 0, gnt_dly: 1,  bp: 0, exp_a0: 22'h000100, exp_a1: 22'h000104};
      vecs[1] = '{base: 22'h002000, gap: 3, gnt_dly: 1,  bp: 0, exp_a0: 22'h002000, exp_a1: 22'h002004};
      vecs[2] = '{base: 22'h000040, gap: 0, gnt_dly: 2,  bp: 1, exp_a0: 22'h000040, exp_a1: 22'h000044};
      vecs[3] = '{base: 22'h3FFFFC, gap: 0, gnt_dly: 10, bp: 0, exp_a0: 22'h3FFFFC, exp_a1: 22'h000000};

      for (int i = 0; i < 4; i++) begin
         do_reset(i == 0);
         base_addr = vecs[i].base;
         gnt_dly   = vecs[i].gnt_dly;
         bp        = vecs[i].bp;
         gap       = vecs[i].gap;
         expect_burst(vecs[i].exp_a0, 4);
         expect_burst(vecs[i].exp_a1, 4);
         if (gap == 0) begin
            preload(8, 16'hA000 + 16'(i * 16));
         end else begin
            feed_word = 16'hA000 + 16'(i * 16);
            to_feed   = 8;
         end
         enable = 1'b1;
         run_until_beats(8, 600);
         enable = 1'b0;
         repeat (4) tick();
         check("idle_after_run", busy, 0);
         check("total_pops", pops, 8);
         check_clean();
      end

      // Reset in the middle of SEND, then restart from a fresh base address.
      do_reset(0);
      base_addr = 22'h000500;
      expect_burst(22'h000500, 4);
      preload(4, 16'hB000);
      enable = 1'b1;
      run_until_beats(2, 100);
      rst_n = 1'b0;
      #1;
      check_reset_vals();
      clear_env();
      repeat (2) @(posedge clk);
      #1;
      base_addr = 22'h000600;
      expect_burst(22'h000600, 4);
      preload(4, 16'hC000);
      rst_n = 1'b1;
      run_until_beats(4, 100);
      check_clean();

      do_reset(0);
      base_addr = 22'h000700;
      preload(3, 16'hD000);
`ifdef WR_BURST_TIMEOUT_EN
      expect_burst(22'h000700, 3);
      expect_burst(22'h000703, 4);
      enable = 1'b1;
      run_until_beats(3, 200);
      check("timeout_wait", (req_cyc >= 64), 1);
      preload(4, 16'hD003);
      run_until_beats(7, 200);
      check_clean();
`else
      enable = 1'b1;
      repeat (150) tick();
      check("no_partial_req", req_seen, 0);
      check("still_fetching", busy, 1);
      check("partial_pops", pops, 3);
      check("no_pop_when_empty", empty_viol, 0);
`endif

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
